// File: rtl/led_pattern_sequencer_pkg.sv
// led_pattern_sequencer_pkg: mode/state/direction encodings and LED count default shared by the sequencer
package led_pattern_sequencer_pkg;
  localparam int LED_NUM_DEF = 8;
  typedef enum logic [1:0] {MODE_HOLD, MODE_WALK_UP, MODE_WALK_DOWN, MODE_PING_PONG} mode_e;
  typedef enum logic {ST_RUN, ST_PAUSE} state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
endpackage

// File: rtl/led_pattern_sequencer_key_debounce.sv
// key_debounce: 2-FF sync + debounce of active-low key_n; press pulses one cycle when accepted level falls (ports clk, rst_n, key_n, press)
module key_debounce #(
  parameter int DEB_TICKS = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEB_TICKS) + 1;
  logic [1:0] sync_q, sync_d;
  logic level_q, level_d, press_q, press_d, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d = {sync_q[0], key_n};
    hit = (sync_q[1] != level_q) && (cnt_q == CW'(DEB_TICKS - 1));
    cnt_d = (sync_q[1] == level_q || hit) ? '0 : cnt_q + CW'(1);
    level_d = hit ? sync_q[1] : level_q;
    press_d = hit && !sync_q[1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: walks led_select across the LED bar in one of four patterns; keys change mode / pause (ports clk, rst_n, key_mode_n, key_pause_n -> led_select, mode, paused, step_strobe)
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int LED_NUM     = LED_NUM_DEF,
  parameter int DWELL_TICKS = 600,
  parameter int DEB_TICKS   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_pause_n,
  output logic [7:0] led_select,
  output logic [1:0] mode,
  output logic       paused,
  output logic       step_strobe
);
  localparam int IW = $clog2(LED_NUM);
  localparam int DW = $clog2(DWELL_TICKS);
  localparam logic [IW-1:0] LAST = IW'(LED_NUM - 1);
  localparam logic [IW-1:0] PENULT = IW'(LED_NUM - 2);
  logic mode_press, pause_press, counting, expire, flip;
  logic strobe_q, strobe_d, paused_q, paused_d;
  logic [IW-1:0] idx_q, idx_d, idx_step;
  logic [DW-1:0] dwell_q, dwell_d;
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  dir_e dir_q, dir_d;
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_mode_key (
    .clk(clk), .rst_n(rst_n), .key_n(key_mode_n), .press(mode_press)
  );
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_pause_key (
    .clk(clk), .rst_n(rst_n), .key_n(key_pause_n), .press(pause_press)
  );
  always_comb begin
    counting = state_q == ST_RUN && mode_q != MODE_HOLD;
    expire = counting && dwell_q == DW'(DWELL_TICKS - 1);
    idx_step = mode_q == MODE_WALK_UP   ? (idx_q == LAST ? '0 : idx_q + IW'(1)) :
               mode_q == MODE_WALK_DOWN ? (idx_q == '0 ? LAST : idx_q - IW'(1)) :
               dir_q == DIR_UP          ? idx_q + IW'(1) : idx_q - IW'(1);
    // ping-pong turns around one step before each end so the end LEDs show once per sweep
    flip = mode_q == MODE_PING_PONG &&
           ((dir_q == DIR_UP && idx_q == PENULT) || (dir_q == DIR_DOWN && idx_q == IW'(1)));
    mode_d = mode_press ? mode_e'(mode_q + 2'd1) : mode_q;
    dwell_d = (mode_press || expire) ? '0 : counting ? dwell_q + DW'(1) : dwell_q;
    idx_d = mode_press ? (mode_d == MODE_WALK_DOWN ? LAST : '0) : expire ? idx_step : idx_q;
    dir_d = mode_press ? DIR_UP : (expire && flip) ? (dir_q == DIR_UP ? DIR_DOWN : DIR_UP) : dir_q;
    strobe_d = expire && !mode_press;
    state_d = pause_press ? (state_q == ST_RUN ? ST_PAUSE : ST_RUN) : state_q;
    paused_d = state_d == ST_PAUSE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      mode_q   <= MODE_WALK_UP;
      dir_q    <= DIR_UP;
      idx_q    <= '0;
      dwell_q  <= '0;
      strobe_q <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      idx_q    <= idx_d;
      dwell_q  <= dwell_d;
      strobe_q <= strobe_d;
      paused_q <= paused_d;
    end
  end
  assign led_select = 8'(idx_q);
  assign mode = mode_q;
  assign paused = paused_q;
  assign step_strobe = strobe_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: random key stimulus checked every cycle against a behavioural pattern model
module tb_led_pattern_sequencer;
  localparam int N = 8, DWT = 4, DB = 3;
  logic clk = 1'b0, rst_n = 1'b0, key_mode_n = 1'b1, key_pause_n = 1'b1;
  logic [7:0] led_select;
  logic [1:0] mode;
  logic paused, step_strobe;
  int checks = 0, errors = 0;
  int m_idx, m_mode, m_ph, m_pos, run[2];
  bit m_paused, m_strobe;
  bit sy0[2], sy1[2], lv[2], pr[2];

  led_pattern_sequencer #(.LED_NUM(N), .DWELL_TICKS(DWT), .DEB_TICKS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode_n(key_mode_n), .key_pause_n(key_pause_n),
    .led_select(led_select), .mode(mode), .paused(paused), .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_idx = 0; m_mode = 1; m_ph = 0; m_pos = 0; m_paused = 0; m_strobe = 0;
    for (int k = 0; k < 2; k++) begin
      sy0[k] = 1; sy1[k] = 1; lv[k] = 1; pr[k] = 0; run[k] = 0;
    end
  endtask

  // ping-pong is a position on a ring of 2N-2 slots folded back onto the LED bar
  task automatic m_edge();
    bit raw[2];
    bit smp;
    raw[0] = key_mode_n;
    raw[1] = key_pause_n;
    m_strobe = 0;
    if (pr[0]) begin
      m_mode = (m_mode + 1) % 4; m_ph = 0; m_pos = 0;
      m_idx = (m_mode == 2) ? N - 1 : 0;
    end else if (!m_paused && m_mode != 0) begin
      if (m_ph == DWT - 1) begin
        m_ph = 0; m_strobe = 1;
        if (m_mode == 1) m_idx = (m_idx + 1) % N;
        else if (m_mode == 2) m_idx = (m_idx + N - 1) % N;
        else begin
          m_pos = (m_pos + 1) % (2 * N - 2);
          m_idx = (m_pos < N) ? m_pos : 2 * N - 2 - m_pos;
        end
      end else m_ph++;
    end
    if (pr[1]) m_paused = !m_paused;
    for (int k = 0; k < 2; k++) begin
      smp = sy1[k]; sy1[k] = sy0[k]; sy0[k] = raw[k]; pr[k] = 0;
      if (smp != lv[k]) begin
        run[k]++;
        if (run[k] == DB) begin lv[k] = smp; run[k] = 0; pr[k] = !smp; end
      end else run[k] = 0;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_edge();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("led_select", led_select, m_idx);
      chk("mode", mode, m_mode);
      chk("paused", paused, m_paused);
      chk("step_strobe", step_strobe, m_strobe);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hit_key(bit pause_key, int hold);
    if (pause_key) key_pause_n = 1'b0; else key_mode_n = 1'b0;
    cyc(hold);
    key_pause_n = 1'b1; key_mode_n = 1'b1;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_led"}, led_select, 0);
    chk({tag, "_mode"}, mode, 1);
    chk({tag, "_paused"}, paused, 0);
    chk({tag, "_strobe"}, step_strobe, 0);
  endtask

  task automatic async_reset(string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int found;
    cyc(2);
    check_reset_values("rst");
    rst_n = 1'b1;
    cyc(4);
    chk("first_step_led", led_select, 1);
    chk("first_step_strobe", step_strobe, 1);
    cyc(32);
    key_mode_n = 1'b0;
    cyc(5);
    chk("press_latency_mode_before", mode, 1);
    cyc(1);
    chk("press_mode_walk_down", mode, 2);
    chk("press_led_last", led_select, N - 1);
    chk("press_no_strobe", step_strobe, 0);
    cyc(4);
    key_mode_n = 1'b1;
    cyc(40);
    hit_key(0, 8);
    cyc(70);
    chk("ping_pong_mode", mode, 3);
    key_mode_n = 1'b0; cyc(2); key_mode_n = 1'b1; cyc(1);
    key_mode_n = 1'b0; cyc(2); key_mode_n = 1'b1;
    cyc(10);
    chk("glitch_no_change", mode, 3);
    hit_key(0, 5);
    cyc(10);
    chk("held5_to_hold", mode, 0);
    hit_key(0, 6);
    cyc(13);
    hit_key(1, 6);
    cyc(4);
    chk("pause_on", paused, 1);
    cyc(20);
    chk("pause_still", paused, 1);
    hit_key(1, 6);
    cyc(20);
    chk("pause_off", paused, 0);
    hit_key(1, 6);
    cyc(6);
    hit_key(0, 6);
    cyc(6);
    chk("mode_in_pause_mode", mode, 2);
    chk("mode_in_pause_paused", paused, 1);
    hit_key(1, 6);
    cyc(8);
    hit_key(0, 6);
    cyc(6);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_mode == 3 && m_idx == 5 && m_pos >= N && m_ph == 1) found = 1;
      else cyc(1);
    end
    chk("reach_pp_down_5", found, 1);
    async_reset("midstep_rst");
    cyc(4);
    chk("after_rst_led", led_select, 1);
    chk("after_rst_mode", mode, 1);
    for (int s = 0; s < 300; s++) begin
      key_mode_n = ($urandom_range(0, 3) != 0);
      key_pause_n = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(1, 12));
      if ($urandom_range(0, 59) == 0) async_reset("rand_rst");
    end
    key_mode_n = 1'b1; key_pause_n = 1'b1;
    cyc(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
